siso_seq_ctrl: RTL and testbench

//   Sequencer for the serial-in/serial-out shift chain. Accepts a parallel word over a

---
 rtl/siso_seq_ctrl.sv | 113 +++++++++++
 tb/tb_siso_seq_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/siso_seq_ctrl.sv
// Loopback sequencer for a serial-in/serial-out shift chain: serialises a host word
// MSB first, flushes the chain, recaptures the returning bits and flags any mismatch.
module siso_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_en,
  input  logic             ser_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             mismatch,
  output logic             busy
);

  localparam int unsigned   CW         = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_FLUSH = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] CAP_START  = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_cap;
  logic [CW-1:0]    r_cyc;
  logic [WIDTH-1:0] w_cap_next;

  // First captured bit walks up to the MSB as later bits enter at the LSB.
  assign w_cap_next = (r_cap << 1) | WIDTH'(ser_in);

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);

  // r_cyc holds the current cycle index t; each edge acts on the cycle just ending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_word    <= '0;
      r_tx      <= '0;
      r_cap     <= '0;
      r_cyc     <= '0;
      ser_out   <= 1'b0;
      ser_en    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      mismatch  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= S_SHIFT;
            r_word  <= in_data;
            r_tx    <= in_data << 1;
            r_cap   <= '0;
            r_cyc   <= '0;
            ser_out <= in_data[WIDTH-1];
            ser_en  <= 1'b1;
          end
        end
        S_SHIFT, S_FLUSH: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_cap   <= '0;
            r_cyc   <= '0;
            ser_out <= 1'b0;
            ser_en  <= 1'b0;
          end else begin
            r_cyc   <= r_cyc + 1'b1;
            // r_tx has shifted out to all zeros by FLUSH, giving the zero fill.
            ser_out <= r_tx[WIDTH-1];
            r_tx    <= r_tx << 1;
            if (r_cyc >= CAP_START) begin
              r_cap <= w_cap_next;
            end
            if (r_cyc == LAST_FLUSH) begin
              r_state   <= S_DONE;
              ser_out   <= 1'b0;
              ser_en    <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= w_cap_next;
              mismatch  <= (w_cap_next != r_word);
            end else if (r_cyc == LAST_SHIFT) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
            mismatch  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_siso_seq_ctrl.sv
// Bench for siso_seq_ctrl: a 4-stage chain gated by ser_en closes the loop, and each
// transfer is predicted cycle by cycle from the word, stall length and fault injections.
module tb_siso_seq_ctrl;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int LAT = W + D;

  logic         clk       = 1'b0;
  logic         rst       = 1'b0;
  logic         in_valid  = 1'b0;
  logic         abort     = 1'b0;
  logic         out_ready = 1'b0;
  logic         inv       = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic [D-1:0] chain     = '0;
  logic         in_ready, ser_out, ser_en, ser_in, out_valid, mismatch, busy;
  logic [W-1:0] out_data;

  int n_chk = 0;
  int n_err = 0;

  siso_seq_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .abort     (abort),
    .ser_out   (ser_out),
    .ser_en    (ser_en),
    .ser_in    (ser_in),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .mismatch  (mismatch),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Attached shift chain; inv flips its output to inject a loopback fault.
  always @(posedge clk) if (ser_en) chain <= {chain[D-2:0], ser_out};
  assign ser_in = chain[D-1] ^ inv;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_ser_en", ser_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_busy", busy, 0);
  endtask

  // Called and returns #1 after a rising edge with the DUT idle.
  // inv_t: cycle whose ser_in is inverted; abort_t: cycle with abort high;
  // stall: DONE cycles with out_ready low; hold: keep in_valid high with nextw.
  task automatic xfer(input logic [W-1:0] w, input int inv_t, input int abort_t,
                      input int stall, input bit hold, input logic [W-1:0] nextw);
    logic [W-1:0] exp_data;
    logic [W-1:0] sh;
    int           hs;
    hs       = LAT + stall;
    exp_data = w;
    // ser_in at cycle t carries the bit sent at t-D, which lands at bit LAT-1-t.
    if (inv_t >= D && inv_t < LAT) exp_data[LAT-1-inv_t] = ~exp_data[LAT-1-inv_t];
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #1;
    for (int t = 0; t <= hs; t++) begin
      in_valid  = hold ? 1'b1 : 1'($urandom_range(0, 1));
      in_data   = hold ? nextw : W'($urandom);
      inv       = (t == inv_t);
      abort     = (t == abort_t) || (t >= LAT && $urandom_range(0, 1) == 1);
      out_ready = (t >= hs) ? 1'b1 : (t >= LAT) ? 1'b0 : 1'($urandom_range(0, 1));
      sh = w << t;
      chk("ser_out", ser_out, sh[W-1]);
      chk("ser_en", ser_en, t < LAT);
      chk("out_valid", out_valid, t >= LAT);
      chk("busy_in_ready", in_ready, 0);
      chk("busy", busy, 1);
      if (t >= LAT) begin
        chk("out_data", out_data, exp_data);
        chk("mismatch", mismatch, exp_data != w);
      end
      if (t == abort_t && t < LAT) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        inv      = 1'b0;
        chk("abort_ser_en", ser_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        return;
      end
      @(posedge clk); #1;
    end
    in_valid  = hold;
    in_data   = nextw;
    abort     = 1'b0;
    inv       = 1'b0;
    out_ready = 1'b0;
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_ser_en", ser_en, 0);
  endtask

  task automatic rst_mid(input logic [W-1:0] w, input int rst_t);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 0; t < rst_t; t++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_ser_en", ser_en, 1);
    rst      = 1'b0;
    in_valid = 1'b1;
    #1;
    chk_reset();
    @(posedge clk); #1;
    chk_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    int           inv_t, ab_t, st;
    #1;
    chk_reset();
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk_reset();
    in_valid = 1'b0;
    rst      = 1'b1;

    xfer(8'hA5, -1, -1, 0, 1'b0, '0);
    xfer(8'h3C, -1, -1, 0, 1'b1, 8'hFF);
    xfer(8'hFF, -1, -1, 0, 1'b0, '0);
    xfer(8'h5A, -1, -1, 5, 1'b0, '0);
    xfer(8'hA5, 4, -1, 0, 1'b0, '0);
    xfer(8'h96, -1, 5, 0, 1'b0, '0);
    xfer(8'h0F, -1, -1, 0, 1'b0, '0);
    xfer(8'h81, -1, LAT + 1, 3, 1'b0, '0);
    xfer(8'h00, LAT - 1, -1, 0, 1'b0, '0);
    rst_mid(8'h77, 6);
    xfer(8'hC3, -1, -1, 0, 1'b0, '0);

    for (int i = 0; i < 40; i++) begin
      w     = W'($urandom);
      inv_t = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, LAT + 2));
      ab_t  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAT + 1)) : -1;
      st    = int'($urandom_range(0, 3));
      xfer(w, inv_t, ab_t, st, 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
